alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-007 SHALL have ports req0_op / req1_op  input  3 each  ALU opcode.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-011 SHALL have port rsp_z  output  WIDTH  result value.
REQ-012 SHALL have port rsp_zero  output  1  high when rsp_z is all zeros.

Function
REQ-013 SHALL share one ALU between two requesters via FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-014 IDLE: if any reqN_valid, SHALL assert reqN_ready combinationally for the granted requester only, register a, b, op, id, then go EXEC; else stay IDLE.
REQ-015 Grant: one valid -> that one; both valid -> the requester not granted last (round robin); pointer updates on every grant.
REQ-016 EXEC: SHALL compute from registered operands, register rsp_z/rsp_zero/rsp_id, set rsp_valid, go RESP.
REQ-017 RESP: SHALL hold rsp_* stable while rsp_valid and not rsp_ready; on rsp_valid and rsp_ready SHALL clear rsp_valid and go IDLE.
REQ-018 Latency: request accepted in cycle N yields rsp_valid in cycle N+2; minimum spacing between accepts is 3 cycles.
REQ-019 req0_ready and req1_ready SHALL never be high in the same cycle, and both SHALL be low outside IDLE.
REQ-020 Opcode: op[1:0]=00 AND; 01 OR; 10 add (op[2]=0) or a-b (op[2]=1), modulo 2^WIDTH; 11 signed a<b giving 1 else 0, regardless of op[2].
REQ-021 Signed less-than SHALL be correct on overflow (e.g. a=0x80000000, b=1 gives 1).
REQ-022 Requester withdrawing valid before acceptance SHALL lose nothing and not be granted.

Reset
REQ-023 On reset: state IDLE, rsp_valid=0, rsp_z=0, rsp_zero=0, rsp_id=0, round-robin pointer=1 (requester 0 wins first tie), stats counters 0.
REQ-024 Reset mid-operation SHALL discard the in-flight operation with no response produced.

Configuration
REQ-025 With macro ALU_ARBITER_STATS_EN defined, SHALL add outputs grant_cnt0 and grant_cnt1 (16 bits each), incremented per grant, saturating at 0xFFFF.
REQ-026 Without ALU_ARBITER_STATS_EN, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package SHALL hold opcode constants (OP_AND=000, OP_OR=001, OP_ADD=010, OP_SUB=110, OP_SLT=111) and the FSM state encoding.
REQ-028 Combinational ALU SHALL be one sub-module, alu_core (inputs a, b, op; outputs z, zero); arbitration/FSM in alu_arbiter.

Verification
REQ-029 req0 only, a=5, b=3, op=110 in cycle 0 -> req0_ready cycle 0; rsp_valid cycle 2, rsp_z=2, rsp_id=0, rsp_zero=0.
REQ-030 Both valid from reset, held -> grants 0,1,0,1 alternating; rsp_id sequence 0,1,0,1.
REQ-031 a=0xFFFFFFFF (-1), b=1, op=111 -> rsp_z=1; a=1, b=0xFFFFFFFF -> rsp_z=0, rsp_zero=1.
REQ-032 rsp_ready low 4 cycles after rsp_valid -> rsp_* stable, both ready low; accept next request only after handshake.
REQ-033 Reset asserted in EXEC -> next cycle rsp_valid=0, IDLE, no response for that op.
REQ-034 With ALU_ARBITER_STATS_EN, 3 grants to req1 -> grant_cnt1=3, grant_cnt0=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcode constants and FSM state encoding shared by the arbiter and its ALU
package alu_arbiter_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_arbiter_alu_core.sv
// alu_core: combinational AND/OR/ADD/SUB/signed-SLT unit with zero flag
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z,
    output logic             zero
);
    logic slt;
    always_comb begin
        slt  = $signed(a) < $signed(b);
        z    = op[1:0] == OP_AND[1:0] ? a & b :
               op[1:0] == OP_OR[1:0]  ? a | b :
               op[1:0] == OP_ADD[1:0] ? (op[2] ? a - b : a + b) :
                                        {{(WIDTH-1){1'b0}}, slt};
        zero = z == '0;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU by two requesters; ALU_ARBITER_STATS_EN adds grant counters
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
`ifdef ALU_ARBITER_STATS_EN
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
`endif
    output logic             rsp_zero
);
    state_t           state;
    logic             last;
    logic             id_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, z;
    logic             zero, gnt0, gnt1;
    // last holds the most recent grant; a tie goes to the other requester
    always_comb begin
        gnt1 = state == IDLE && req1_valid && (!req0_valid || !last);
        gnt0 = state == IDLE && req0_valid && !gnt1;
    end
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    alu_core #(.WIDTH(WIDTH)) u_alu (.a(a_r), .b(b_r), .op(op_r), .z(z), .zero(zero));
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_z     <= '0;
            rsp_zero  <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt0 || gnt1) begin
                    a_r   <= gnt1 ? req1_a : req0_a;
                    b_r   <= gnt1 ? req1_b : req0_b;
                    op_r  <= gnt1 ? req1_op : req0_op;
                    id_r  <= gnt1;
                    last  <= gnt1;
                    state <= EXEC;
                end
                EXEC: begin
                    rsp_z     <= z;
                    rsp_zero  <= zero;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ALU_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (gnt0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (gnt1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (optionally with ALU_ARBITER_STATS_EN)
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        rsp_valid, rsp_id, rsp_zero;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_z;
`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif
    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
`ifdef ALU_ARBITER_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // single request from IDLE with rsp_ready high; ends back in IDLE
    task automatic run(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] ez, input logic ezero,
                       input string tag);
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        #1;
        chk({tag, "_grant"}, {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk({tag, "_exec_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        chk({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_z"}, rsp_z, ez);
        chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, ezero});
        chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_z", rsp_z, 32'd0);
        chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
        chk("rst_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        reset = 1'b0;

        run(1'b0, 32'd5, 32'd3, 3'b110, 32'd2, 1'b0, "sub");
        chk("post_idle_valid", {31'd0, rsp_valid}, 32'd0);

        // both held from reset: grants alternate 0,1,0,1
        do_reset();
        req0_a = 32'd10; req0_b = 32'd3; req0_op = 3'b010;
        req1_a = 32'd7;  req1_b = 32'd7; req1_op = 3'b110;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", {30'd0, req1_ready, req0_ready}, (k % 2) ? 32'd2 : 32'd1);
            tick();
            chk("rr_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
            chk("rr_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rr_id", {31'd0, rsp_id}, k % 2);
            chk("rr_z", rsp_z, (k % 2) ? 32'd0 : 32'd13);
            chk("rr_zero", {31'd0, rsp_zero}, k % 2);
            chk("rr_resp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
        end

        run(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 1'b0, "slt_neg");
        run(1'b0, 32'd1, 32'hFFFF_FFFF, 3'b111, 32'd0, 1'b1, "slt_pos");
        run(1'b0, 32'h8000_0000, 32'd1, 3'b111, 32'd1, 1'b0, "slt_ovf");
        run(1'b1, 32'h8000_0000, 32'd1, 3'b011, 32'd1, 1'b0, "slt_op011");
        run(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'd0, 1'b1, "slt_ovf2");
        run(1'b1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, 32'h00F0_000F, 1'b0, "and");
        run(1'b0, 32'hF000_0001, 32'h0000_0F00, 3'b001, 32'hF000_0F01, 1'b0, "or");
        run(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, 1'b1, "add_wrap");
        run(1'b0, 32'd0, 32'd1, 3'b110, 32'hFFFF_FFFF, 1'b0, "sub_wrap");

        // back-pressure: response held, withdrawn req1 not granted afterwards
        rsp_ready = 1'b0;
        req0_a = 32'd3; req0_b = 32'd4; req0_op = 3'b001; req0_valid = 1'b1;
        #1;
        chk("bp_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000; req0_valid = 1'b1;
        req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b010; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_z", rsp_z, 32'd7);
            chk("bp_id", {31'd0, rsp_id}, 32'd0);
            chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            if (i == 3) req1_valid = 1'b0;
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("bp_hs_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_withdraw_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("bp_next_z", rsp_z, 32'd1);
        chk("bp_next_id", {31'd0, rsp_id}, 32'd0);
        tick();

        // reset while in EXEC discards the operation
        req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'b010; req0_valid = 1'b1;
        #1;
        chk("rx_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rx_valid0", {31'd0, rsp_valid}, 32'd0);
        tick();
        tick();
        chk("rx_valid2", {31'd0, rsp_valid}, 32'd0);
        chk("rx_z", rsp_z, 32'd0);
        run(1'b0, 32'd6, 32'd9, 3'b010, 32'd15, 1'b0, "rx_after");

`ifdef ALU_ARBITER_STATS_EN
        do_reset();
        for (int g = 0; g < 3; g++) run(1'b1, 32'd1, 32'd2, 3'b010, 32'd3, 1'b0, "stats_run");
        chk("stats_cnt1", {16'd0, grant_cnt1}, 32'd3);
        chk("stats_cnt0", {16'd0, grant_cnt0}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
